// File: rtl/alu_result_buffer.sv
// alu_result_buffer
// Capture stage behind the opcode-sequencer/ALU. It samples `result` into a
// show-ahead FIFO, presents the head to a consumer, and keeps debug statistics:
// a wrapping sum, a saturating accepted-sample count and a sticky overflow flag.
//
// Handshake: the head entry transfers on a rising edge where
// out_valid && out_ready are both 1. out_valid never depends on out_ready.
// out_data is stable while out_valid=1 and the head is not popped.
// out_ready while out_valid=0 has no effect.
module alu_result_buffer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int SUM_W  = 16,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     sample_en,
    input  logic [DATA_W-1:0]        result,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     overflow,
    output logic [SUM_W-1:0]         sum,
    output logic [CNT_W-1:0]         sample_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count_q;
    logic              push;
    logic              pop;

    // Occupancy flags come from the entry count so a full FIFO and an empty
    // FIFO are never confused when the pointers coincide.
    assign out_valid = (count_q != '0);
    assign full      = (count_q == DEPTH_C);
    assign count     = count_q;

    // A pop frees a slot in the same edge, so a full FIFO can still accept.
    assign pop  = out_valid & out_ready;
    assign push = sample_en & (~full | pop);

    // Show-ahead head; memory is not reset, so mask it while empty.
    assign out_data = out_valid ? mem[rd_ptr] : '0;

    // Sample storage: write the incoming result at the tail on an accepted push.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr] <= result;
        end
    end

    // Pointers, occupancy and statistics; clear wins over push and pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow   <= 1'b0;
            sum        <= '0;
            sample_cnt <= '0;
        end else if (clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow   <= 1'b0;
            sum        <= '0;
            sample_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                sum    <= sum + SUM_W'(result);
                if (sample_cnt != '1) begin
                    sample_cnt <= sample_cnt + 1'b1;
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
            // A requested sample that could not be stored is a drop.
            if (sample_en && !push) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_result_buffer.sv
// Bench for alu_result_buffer: directed scenarios with literal expectations,
// then randomized traffic, all checked against a queue-based model.
module tb_alu_result_buffer;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;
    localparam int SUM_W  = 16;
    localparam int CNT_W  = 16;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  clear = 1'b0;
    logic                  sample_en = 1'b0;
    logic [DATA_W-1:0]     result = '0;
    logic                  out_ready = 1'b0;
    logic [DATA_W-1:0]     out_data;
    logic                  out_valid;
    logic [$clog2(DEPTH):0] count;
    logic                  full;
    logic                  overflow;
    logic [SUM_W-1:0]      sum;
    logic [CNT_W-1:0]      sample_cnt;

    // Clock / reset block
    always #5 clk = ~clk;

    alu_result_buffer #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .SUM_W(SUM_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .clear(clear), .sample_en(sample_en),
        .result(result), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .count(count), .full(full),
        .overflow(overflow), .sum(sum), .sample_cnt(sample_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Scoreboard / model state
    logic [DATA_W-1:0] exp_q[$];
    int m_sum = 0;
    int m_cnt = 0;
    bit m_ovf = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: FIFO as a queue, statistics as plain integers.
    always @(posedge clk or negedge rst) begin
        bit do_pop;
        bit do_push;
        if (!rst) begin
            exp_q.delete();
            m_sum = 0;
            m_cnt = 0;
            m_ovf = 1'b0;
        end else if (clear) begin
            exp_q.delete();
            m_sum = 0;
            m_cnt = 0;
            m_ovf = 1'b0;
        end else begin
            do_pop  = (exp_q.size() > 0) && out_ready;
            do_push = sample_en && ((exp_q.size() < DEPTH) || do_pop);
            if (do_pop) void'(exp_q.pop_front());
            if (do_push) begin
                exp_q.push_back(result);
                m_sum = (m_sum + int'(result)) % 65536;
                if (m_cnt < 65535) m_cnt++;
            end else if (sample_en) begin
                m_ovf = 1'b1;
            end
        end
    end

    // Compare process: every falling edge, DUT outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("out_valid",  32'(out_valid),  32'(exp_q.size() != 0));
            check("count",      32'(count),      exp_q.size());
            check("full",       32'(full),       32'(exp_q.size() == DEPTH));
            check("overflow",   32'(overflow),   32'(m_ovf));
            check("sum",        32'(sum),        m_sum);
            check("sample_cnt", 32'(sample_cnt), m_cnt);
            check("out_data",   32'(out_data),   (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'd0);
        end
    end

    // Driver: apply inputs just after a falling edge, return after the next one.
    task automatic cyc(input bit se, input logic [DATA_W-1:0] res, input bit rdy, input bit clr);
        sample_en = se;
        result    = res;
        out_ready = rdy;
        clear     = clr;
        @(negedge clk);
        #1;
    endtask

    logic [DATA_W-1:0] t2_vals[8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    logic [DATA_W-1:0] t3_vals[8] = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h99};

    initial begin
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_valid", 32'(out_valid), 0);
        check("reset_count", 32'(count), 0);
        check("reset_data",  32'(out_data), 0);
        rst = 1'b1;
        chk_en = 1'b1;

        // Three pushes with the consumer stalled
        cyc(1, 8'h11, 0, 0);
        cyc(1, 8'h22, 0, 0);
        cyc(1, 8'h33, 0, 0);
        cyc(0, 8'h00, 0, 0);
        check("t1_count", 32'(count), 3);
        check("t1_data",  32'(out_data), 32'h11);
        check("t1_sum",   32'(sum), 32'h0066);
        check("t1_cnt",   32'(sample_cnt), 3);

        // Fill to eight, then one dropped sample
        for (int i = 3; i < 8; i++) cyc(1, t2_vals[i], 0, 0);
        cyc(1, 8'hEE, 0, 0);
        check("t2_count", 32'(count), 8);
        check("t2_full",  32'(full), 1);
        check("t2_ovf",   32'(overflow), 1);
        check("t2_sum",   32'(sum), 32'h0264);
        check("t2_cnt",   32'(sample_cnt), 8);
        for (int i = 0; i < 8; i++) begin
            check("t2_drain", 32'(out_data), 32'(t2_vals[i]));
            cyc(0, 8'h00, 1, 0);
        end
        check("t2_empty", 32'(out_valid), 0);

        // Full FIFO with simultaneous push and pop
        cyc(0, 8'h00, 0, 1);
        for (int i = 1; i <= 8; i++) cyc(1, 8'(i), 0, 0);
        cyc(1, 8'h99, 1, 0);
        check("t3_count", 32'(count), 8);
        check("t3_ovf",   32'(overflow), 0);
        for (int i = 0; i < 8; i++) begin
            check("t3_drain", 32'(out_data), 32'(t3_vals[i]));
            cyc(0, 8'h00, 1, 0);
        end

        // Streaming 258 x 0xFF: 258*255 = 0x100FE, wraps to 0x00FE
        cyc(0, 8'h00, 0, 1);
        repeat (258) cyc(1, 8'hFF, 1, 0);
        check("t4_sum", 32'(sum), 32'h00FE);
        check("t4_cnt", 32'(sample_cnt), 258);
        cyc(0, 8'h00, 1, 0);
        check("t4_empty", 32'(out_valid), 0);

        // Clear beats a simultaneous push and pop
        cyc(0, 8'h00, 0, 1);
        for (int i = 0; i < 8; i++) cyc(1, 8'($urandom_range(0, 255)), 0, 0);
        cyc(1, 8'hAB, 0, 0);
        repeat (3) cyc(0, 8'h00, 1, 0);
        check("t5_count_pre", 32'(count), 5);
        check("t5_ovf_pre",   32'(overflow), 1);
        cyc(1, 8'h77, 1, 1);
        check("t5_count", 32'(count), 0);
        check("t5_valid", 32'(out_valid), 0);
        check("t5_sum",   32'(sum), 0);
        check("t5_ovf",   32'(overflow), 0);
        check("t5_cnt",   32'(sample_cnt), 0);

        // Asynchronous reset between edges with four entries held
        cyc(0, 8'h00, 0, 1);
        for (int i = 0; i < 4; i++) cyc(1, 8'hA0 + 8'(i), 0, 0);
        cyc(0, 8'h00, 0, 0);
        check("t6_count_pre", 32'(count), 4);
        #2 rst = 1'b0;
        #1;
        check("t6_valid", 32'(out_valid), 0);
        check("t6_count", 32'(count), 0);
        check("t6_sum",   32'(sum), 0);
        check("t6_cnt",   32'(sample_cnt), 0);
        check("t6_data",  32'(out_data), 0);
        @(negedge clk);
        #1 rst = 1'b1;
        cyc(1, 8'h5A, 0, 0);
        cyc(0, 8'h00, 0, 0);
        check("t6_after_data",  32'(out_data), 32'h5A);
        check("t6_after_count", 32'(count), 1);
        cyc(0, 8'h00, 1, 0);

        // Randomized traffic with varying consumer pressure
        for (int i = 0; i < 3000; i++) begin
            int pr;
            pr = ((i / 500) % 3 == 0) ? 2 : (((i / 500) % 3 == 1) ? 5 : 9);
            cyc($urandom_range(0, 9) < 7, 8'($urandom_range(0, 255)),
                $urandom_range(0, 9) < pr, $urandom_range(0, 99) == 0);
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
